// File: rtl/morse_pkg.sv
// morse_pkg: shared keyer states, character codes and limits; MORSE_SPACE_EN makes code 36 (word space) valid
package morse_pkg;
  typedef enum logic [2:0] {IDLE, MARK, EGAP, LGAP, WGAP} state_t;
  localparam logic [5:0] CH_A = 6'd0;
  localparam logic [5:0] CH_0 = 6'd26;
  localparam logic [5:0] CH_SPACE = 6'd36;
`ifdef MORSE_SPACE_EN
  localparam logic [5:0] CH_MAX_VALID = 6'd36;
`else
  localparam logic [5:0] CH_MAX_VALID = 6'd35;
`endif
  localparam int MAX_LEN = 5;
endpackage

// File: rtl/morse_rom.sv
// morse_rom: combinational code->Morse lookup; in_char[5:0] in, valid/len[2:0]/pat[4:0] out (pat MSB-first, 1=dash, left-aligned); space has len 0
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] in_char,
  output logic       valid,
  output logic [2:0] len,
  output logic [4:0] pat
);
  always_comb begin
    {len, pat} = 8'h00;
    case (in_char)
      6'd0:  {len, pat} = {3'd2, 5'b01000};
      6'd1:  {len, pat} = {3'd4, 5'b10000};
      6'd2:  {len, pat} = {3'd4, 5'b10100};
      6'd3:  {len, pat} = {3'd3, 5'b10000};
      6'd4:  {len, pat} = {3'd1, 5'b00000};
      6'd5:  {len, pat} = {3'd4, 5'b00100};
      6'd6:  {len, pat} = {3'd3, 5'b11000};
      6'd7:  {len, pat} = {3'd4, 5'b00000};
      6'd8:  {len, pat} = {3'd2, 5'b00000};
      6'd9:  {len, pat} = {3'd4, 5'b01110};
      6'd10: {len, pat} = {3'd3, 5'b10100};
      6'd11: {len, pat} = {3'd4, 5'b01000};
      6'd12: {len, pat} = {3'd2, 5'b11000};
      6'd13: {len, pat} = {3'd2, 5'b10000};
      6'd14: {len, pat} = {3'd3, 5'b11100};
      6'd15: {len, pat} = {3'd4, 5'b01100};
      6'd16: {len, pat} = {3'd4, 5'b11010};
      6'd17: {len, pat} = {3'd3, 5'b01000};
      6'd18: {len, pat} = {3'd3, 5'b00000};
      6'd19: {len, pat} = {3'd1, 5'b10000};
      6'd20: {len, pat} = {3'd3, 5'b00100};
      6'd21: {len, pat} = {3'd4, 5'b00010};
      6'd22: {len, pat} = {3'd3, 5'b01100};
      6'd23: {len, pat} = {3'd4, 5'b10010};
      6'd24: {len, pat} = {3'd4, 5'b10110};
      6'd25: {len, pat} = {3'd4, 5'b11000};
      6'd26: {len, pat} = {3'd5, 5'b11111};
      6'd27: {len, pat} = {3'd5, 5'b01111};
      6'd28: {len, pat} = {3'd5, 5'b00111};
      6'd29: {len, pat} = {3'd5, 5'b00011};
      6'd30: {len, pat} = {3'd5, 5'b00001};
      6'd31: {len, pat} = {3'd5, 5'b00000};
      6'd32: {len, pat} = {3'd5, 5'b10000};
      6'd33: {len, pat} = {3'd5, 5'b11000};
      6'd34: {len, pat} = {3'd5, 5'b11100};
      6'd35: {len, pat} = {3'd5, 5'b11110};
      default: {len, pat} = 8'h00;
    endcase
    valid = in_char <= CH_MAX_VALID;
  end
endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: valid/ready char in (CLOCK, reset, in_valid, in_char[5:0], in_ready) -> Morse keying (key), busy, err pulse on bad code; MORSE_SPACE_EN enables 4-unit word space
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int CNT_W = $clog2(UNIT_CYCLES*3+1)
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [5:0] in_char,
  output logic       in_ready,
  output logic       key,
  output logic       busy,
  output logic       err
);
  localparam logic [CNT_W-1:0] U1 = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] U3 = CNT_W'(3*UNIT_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_n;
  logic [CNT_W-1:0] dur, dur_n;
  logic [4:0] sh, sh_n, rom_pat;
  logic [2:0] cnt, cnt_n, rom_len;
  logic key_n, err_n, rom_valid, accept, last;
  morse_rom u_rom (.in_char(in_char), .valid(rom_valid), .len(rom_len), .pat(rom_pat));
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = in_valid & in_ready;
  assign last = dur == ONE;
  always_comb begin
    state_n = state;
    dur_n = state == IDLE ? dur : dur - ONE;
    sh_n = sh;
    cnt_n = cnt;
    key_n = key;
    err_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (!rom_valid) err_n = 1'b1;
`ifdef MORSE_SPACE_EN
        else if (in_char == CH_SPACE) begin
          state_n = WGAP;
          dur_n = U1;
          cnt_n = 3'd4;
        end
`endif
        else begin
          state_n = MARK;
          sh_n = rom_pat;
          cnt_n = rom_len;
          dur_n = rom_pat[4] ? U3 : U1;
          key_n = 1'b1;
        end
      end
      MARK: if (last) begin
        key_n = 1'b0;
        state_n = cnt != 3'd1 ? EGAP : LGAP;
        dur_n = cnt != 3'd1 ? U1 : U3;
      end
      EGAP: if (last) begin
        state_n = MARK;
        key_n = 1'b1;
        sh_n = sh << 1;
        cnt_n = cnt - 3'd1;
        dur_n = sh[3] ? U3 : U1;
      end
      LGAP: if (last) state_n = IDLE;
`ifdef MORSE_SPACE_EN
      WGAP: if (last) begin
        cnt_n = cnt - 3'd1;
        dur_n = U1;
        state_n = cnt == 3'd1 ? IDLE : WGAP;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state <= IDLE;
      dur <= '0;
      sh <= '0;
      cnt <= '0;
      key <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      dur <= dur_n;
      sh <= sh_n;
      cnt <= cnt_n;
      key <= key_n;
      err <= err_n;
    end
  end
endmodule
